flash_spi_reader: RTL and testbench

- SPI master that sequences the external configuration/data SPI flash on behalf of the STM32 bus interface.
- Turns the interface's FLASH_enable / FLASH_data_out / FLASH_continue_read handshake into JEDEC READ (0x03) transactions.
- Returns one byte at a time on FLASH_data_in, qualified by FLASH_busy.
- After reset it wakes the flash from deep power-down before accepting reads.

---
 rtl/flash_spi_reader.sv | 223 ++++++++++++++++++++++
 tb/tb_flash_spi_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_spi_reader.sv
// SPI flash read sequencer: wakes the flash from deep power-down after reset,
// then converts the enable / continue-read handshake into JEDEC READ (0x03)
// transactions, returning one byte at a time. SPI mode 0, MSB first.
module flash_spi_reader #(
  parameter int CLK_DIV          = 2,
  parameter int WAKE_WAIT_CYCLES = 3000,
  parameter int CS_GAP_CYCLES    = 8
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       FLASH_enable,
  input  logic [7:0] FLASH_data_out,
  input  logic       FLASH_continue_read,
  output logic [7:0] FLASH_data_in,
  output logic       FLASH_busy,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int DW = $clog2(2 * CLK_DIV + 1);

  typedef enum logic [2:0] {
    S_WAKE_CMD,
    S_WAKE_WAIT,
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_HOLD,
    S_CSGAP
  } state_t;

  state_t      state_q, state_d;
  logic [DW-1:0] div_q, div_d;       // position inside the current bit
  logic [5:0]  bit_q, bit_d;         // bits completed in the current phase
  logic [31:0] wait_q, wait_d;       // CS-high wait counter
  logic [31:0] tx_q, tx_d;           // outgoing bits, MSB drives spi_mosi
  logic [7:0]  rx_q, rx_d;           // incoming byte being assembled
  logic [7:0]  sector_q, sector_d;
  logic        en_prev_q;
  logic        pend_q, pend_d;       // enable edge seen during CS gap
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        busy_q, busy_d;
  logic [7:0]  data_q, data_d;

  logic en_rise;
  logic half_end;
  logic bit_end;
  logic shifting;

  assign en_rise  = FLASH_enable & ~en_prev_q;
  assign half_end = (div_q == DW'(CLK_DIV - 1));
  assign bit_end  = (div_q == DW'(2 * CLK_DIV - 1));
  assign shifting = ((state_q == S_WAKE_CMD) && !cs_n_q) || (state_q == S_CMD) ||
                    (state_q == S_ADDR) || (state_q == S_DATA);

  assign FLASH_data_in = data_q;
  assign FLASH_busy    = busy_q;
  assign spi_cs_n      = cs_n_q;
  assign spi_sck       = sck_q;
  assign spi_mosi      = tx_q[31];

  // State and datapath registers; reset returns to the wake-up sequence.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= S_WAKE_CMD;
      div_q     <= '0;
      bit_q     <= '0;
      wait_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      sector_q  <= '0;
      en_prev_q <= 1'b0;
      pend_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      busy_q    <= 1'b1;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      wait_q    <= wait_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sector_q  <= sector_d;
      en_prev_q <= FLASH_enable;
      pend_q    <= pend_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
    end
  end

  // Bit engine plus next-state and output decode.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    wait_d   = wait_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    sector_d = sector_q;
    pend_d   = pend_q;
    cs_n_d   = cs_n_q;
    sck_d    = sck_q;
    busy_d   = busy_q;
    data_d   = data_q;

    // Common bit timing: low half, rising edge samples miso, high half,
    // falling edge advances mosi to the next bit.
    if (shifting) begin
      div_d = div_q + DW'(1);
      if (half_end) begin
        sck_d = 1'b1;
        rx_d  = {rx_q[6:0], spi_miso};
      end
      if (bit_end) begin
        div_d = '0;
        sck_d = 1'b0;
        bit_d = bit_q + 6'd1;
        tx_d  = {tx_q[30:0], 1'b0};
      end
    end

    case (state_q)
      S_WAKE_CMD: begin
        if (cs_n_q) begin
          cs_n_d = 1'b0;
          tx_d   = {8'hAB, 24'h000000};
          div_d  = '0;
          bit_d  = '0;
          sck_d  = 1'b0;
        end else if (bit_end && (bit_q == 6'd7)) begin
          state_d = S_WAKE_WAIT;
          cs_n_d  = 1'b1;
          wait_d  = '0;
        end
      end
      S_WAKE_WAIT: begin
        wait_d = wait_q + 32'd1;
        if (wait_q == 32'(WAKE_WAIT_CYCLES - 1)) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        pend_d = 1'b0;
        if (en_rise || pend_q) begin
          if (en_rise) begin
            sector_d = FLASH_data_out;
            tx_d     = {8'h03, FLASH_data_out, 16'h0000};
          end else begin
            tx_d     = {8'h03, sector_q, 16'h0000};
          end
          state_d = S_CMD;
          cs_n_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b0;
        end
      end
      S_CMD, S_ADDR, S_DATA, S_HOLD: begin
        if (!FLASH_enable) begin
          // Abort: drop the partial byte and release the flash.
          state_d = S_CSGAP;
          cs_n_d  = 1'b1;
          sck_d   = 1'b0;
          busy_d  = 1'b1;
          tx_d    = '0;
          div_d   = '0;
          bit_d   = '0;
          wait_d  = '0;
        end else begin
          case (state_q)
            S_CMD: begin
              if (bit_end && (bit_q == 6'd7)) state_d = S_ADDR;
            end
            S_ADDR: begin
              if (bit_end && (bit_q == 6'd31)) begin
                state_d = S_DATA;
                bit_d   = '0;
                tx_d    = '0;
              end
            end
            S_DATA: begin
              tx_d = '0;
              if (bit_end && (bit_q == 6'd7)) begin
                state_d = S_HOLD;
                data_d  = rx_q;
                busy_d  = 1'b0;
              end
            end
            default: begin
              if (FLASH_continue_read) begin
                state_d = S_DATA;
                busy_d  = 1'b1;
                div_d   = '0;
                bit_d   = '0;
                sck_d   = 1'b0;
              end
            end
          endcase
        end
      end
      S_CSGAP: begin
        if (en_rise) begin
          pend_d   = 1'b1;
          sector_d = FLASH_data_out;
        end
        wait_d = wait_q + 32'd1;
        if (wait_q == 32'(CS_GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_WAKE_CMD;
    endcase
  end

endmodule

// File: tb/tb_flash_spi_reader.sv
// Bench for flash_spi_reader: behavioural SPI flash model, transaction and
// read-byte scoreboards fed by directed stimulus.
module tb_flash_spi_reader;

  logic       clk = 1'b0;
  logic       reset_in = 1'b1;
  logic       FLASH_enable = 1'b0;
  logic [7:0] FLASH_data_out = 8'h00;
  logic       FLASH_continue_read = 1'b0;
  logic [7:0] FLASH_data_in;
  logic       FLASH_busy;
  logic       spi_cs_n;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  flash_spi_reader #(.CLK_DIV(2), .WAKE_WAIT_CYCLES(3000), .CS_GAP_CYCLES(8)) dut (
    .clk_in(clk), .reset_in(reset_in), .FLASH_enable(FLASH_enable),
    .FLASH_data_out(FLASH_data_out), .FLASH_continue_read(FLASH_continue_read),
    .FLASH_data_in(FLASH_data_in), .FLASH_busy(FLASH_busy), .spi_cs_n(spi_cs_n),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic [7:0] d; int c; } rd_t;
  typedef struct { logic [7:0] cmd; logic [23:0] addr; int nbits; int min_gap; } tr_t;
  rd_t rd_q[$];
  tr_t tr_q[$];

  // Flash model state
  logic [7:0]  model_bytes [0:7];
  int          model_n = 0;
  logic        cs_prev = 1'b1;
  logic        sck_prev = 1'b0;
  int          nbits = 0;
  logic [7:0]  cmd_sh = 8'h00;
  logic [23:0] addr_sh = 24'h0;
  int          rise_cyc = 0;
  int          last_gap = 0;
  int          n_rises = 0;
  logic        busy_prev = 1'b1;

  // Behavioural flash: captures command/address on sck rise, drives read
  // data on sck fall, checks each completed transaction against tr_q.
  always @(negedge clk) begin
    automatic int bi;
    automatic logic [7:0] b;
    automatic tr_t e;
    if (cs_prev && !spi_cs_n) begin
      nbits    <= 0;
      last_gap <= cyc - rise_cyc;
      spi_miso <= 1'b0;
    end else if (!spi_cs_n) begin
      if (spi_sck && !sck_prev) begin
        if (nbits < 8) cmd_sh <= {cmd_sh[6:0], spi_mosi};
        else if (nbits < 32) addr_sh <= {addr_sh[22:0], spi_mosi};
        nbits <= nbits + 1;
      end else if (!spi_sck && sck_prev) begin
        if (nbits >= 32 && cmd_sh == 8'h03) begin
          bi = (nbits - 32) / 8;
          b  = (bi < model_n) ? model_bytes[bi] : 8'h00;
          spi_miso <= b[7 - ((nbits - 32) % 8)];
        end else begin
          spi_miso <= 1'b0;
        end
      end
    end
    if (!cs_prev && spi_cs_n) begin
      rise_cyc <= cyc;
      n_rises  <= n_rises + 1;
      spi_miso <= 1'b0;
      if (tr_q.size() == 0) begin
        chk("unexpected_transaction_cmd", {24'h0, cmd_sh}, 32'hFFFF_FFFF);
      end else begin
        e = tr_q.pop_front();
        chk("tr_cmd", {24'h0, cmd_sh}, {24'h0, e.cmd});
        if (e.nbits > 0) chk("tr_nbits", nbits, e.nbits);
        if (nbits >= 32 && e.cmd == 8'h03) chk("tr_addr", {8'h0, addr_sh}, {8'h0, e.addr});
        chk("tr_cs_gap_ok", (last_gap >= e.min_gap), 1);
      end
    end
    cs_prev  <= spi_cs_n;
    sck_prev <= spi_sck;
  end

  // Read-byte monitor: every busy 1->0 transition delivers one byte.
  always @(negedge clk) begin
    automatic rd_t e;
    if (!reset_in && busy_prev && !FLASH_busy) begin
      if (rd_q.size() == 0) begin
        chk("unexpected_byte", {24'h0, FLASH_data_in}, 32'hFFFF_FFFF);
      end else begin
        e = rd_q.pop_front();
        chk("rd_data", {24'h0, FLASH_data_in}, {24'h0, e.d});
        if (e.c >= 0) chk("rd_cycle", cyc, e.c);
      end
    end
    busy_prev <= FLASH_busy;
  end

  task automatic wait_byte(input string nm);
    int g = 0;
    while (FLASH_busy && g < 400) begin step(); g++; end
    chk(nm, FLASH_busy, 0);
  endtask

  task automatic pulse_cont();
    FLASH_continue_read = 1'b1;
    step();
    FLASH_continue_read = 1'b0;
  endtask

  initial begin
    int W, N, P, A, r0, g;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_sck", spi_sck, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_busy", FLASH_busy, 1);
    chk("rst_data", {24'h0, FLASH_data_in}, 0);

    // Wake-up: 0xAB, then CS high; enable activity during wake is ignored.
    tr_q.push_back('{cmd: 8'hAB, addr: 24'h0, nbits: 8, min_gap: 0});
    step();
    reset_in = 1'b0;
    r0 = n_rises;
    repeat (3) step();
    FLASH_enable = 1'b1;
    repeat (3) step();
    FLASH_enable = 1'b0;
    g = 0;
    while (n_rises == r0 && g < 300) begin step(); g++; end
    chk("wake_cmd_done", (n_rises != r0), 1);
    W = rise_cyc;
    FLASH_data_out = 8'h12;
    g = 0;
    while (cyc < W + 3000 && g < 4000) begin
      if (cyc == W + 100) FLASH_enable = 1'b1;
      if (cyc == W + 2000) FLASH_enable = 1'b0;
      step();
      g++;
    end
    chk("wake_idle_cs_high", spi_cs_n, 1);

    // First read of sector 0x12, then streaming.
    model_bytes[0] = 8'hA5; model_bytes[1] = 8'h01; model_bytes[2] = 8'h80;
    model_bytes[3] = 8'hFF; model_bytes[4] = 8'h5A; model_n = 5;
    tr_q.push_back('{cmd: 8'h03, addr: 24'h120000, nbits: 72, min_gap: 3000});
    FLASH_enable = 1'b1;
    N = cyc;
    rd_q.push_back('{d: 8'hA5, c: N + 161});
    wait_byte("first_byte_wait");

    for (int i = 1; i <= 3; i++) begin
      repeat (3) step();
      P = cyc;
      rd_q.push_back('{d: model_bytes[i], c: P + 33});
      pulse_cont();
      if (i == 1) begin
        step();
        chk("hold_busy_during_shift", FLASH_busy, 1);
        chk("hold_data_during_shift", {24'h0, FLASH_data_in}, 32'hA5);
      end
      chk("stream_cs_low", spi_cs_n, 0);
      wait_byte("stream_wait");
    end

    // Continue-read while busy is ignored.
    repeat (2) step();
    P = cyc;
    rd_q.push_back('{d: 8'h5A, c: P + 33});
    pulse_cont();
    repeat (4) step();
    pulse_cont();
    wait_byte("ignore_wait");
    repeat (60) step();
    chk("ignore_busy_low", FLASH_busy, 0);
    chk("ignore_data", {24'h0, FLASH_data_in}, 32'h5A);

    // End streaming transaction by dropping enable.
    FLASH_enable = 1'b0;
    step();
    chk("end_cs_high", spi_cs_n, 1);
    chk("end_busy", FLASH_busy, 1);
    repeat (12) step();

    // Abort in the middle of the address phase.
    model_bytes[0] = 8'hC3; model_bytes[1] = 8'h3C; model_n = 2;
    tr_q.push_back('{cmd: 8'h03, addr: 24'h340000, nbits: 0, min_gap: 8});
    FLASH_data_out = 8'h34;
    FLASH_enable = 1'b1;
    N = cyc;
    while (cyc < N + 66) step();
    FLASH_enable = 1'b0;
    step();
    chk("abort_cs_n", spi_cs_n, 1);
    chk("abort_sck", spi_sck, 0);
    chk("abort_busy", FLASH_busy, 1);
    chk("abort_mosi", spi_mosi, 0);
    chk("abort_data_kept", {24'h0, FLASH_data_in}, 32'h5A);
    FLASH_enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("csgap_cs_high", spi_cs_n, 1);
    end

    // Pending edge restarts the read with 0x03.
    tr_q.push_back('{cmd: 8'h03, addr: 24'h340000, nbits: 0, min_gap: 8});
    rd_q.push_back('{d: 8'hC3, c: -1});
    wait_byte("restart_wait");

    // Reset during DATA.
    pulse_cont();
    repeat (10) step();
    reset_in = 1'b1;
    FLASH_enable = 1'b0;
    step();
    chk("mid_rst_cs_n", spi_cs_n, 1);
    chk("mid_rst_busy", FLASH_busy, 1);
    chk("mid_rst_data", {24'h0, FLASH_data_in}, 0);
    chk("mid_rst_sck", spi_sck, 0);
    tr_q.push_back('{cmd: 8'hAB, addr: 24'h0, nbits: 8, min_gap: 0});
    step();
    reset_in = 1'b0;
    g = 0;
    while (tr_q.size() != 0 && g < 300) begin step(); g++; end
    chk("rewake_done", tr_q.size(), 0);
    repeat (50) step();
    chk("rd_queue_empty", rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
